fa_serial_adder: RTL and testbench
==================================

Name: fa_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit full adders. Processes a WIDTH-bit operand pair through a chain of BITS_PER_CYC full-adder cells per clock, with a registered carry between steps. Uses valid/ready handshakes on input and output, so it can sit between a register-file read stage and a result write-back stage.

Parameters:
WIDTH, 8, operand/result width in bits; legal range is 2 or more.
BITS_PER_CYC, 1, bits added per clock; must divide WIDTH exactly.
STEPS (localparam), WIDTH/BITS_PER_CYC, number of RUN cycles per operation.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in (add) or borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
s  output  WIDTH  sum/difference
co  output  1  carry-out; in sub mode, 1 = no borrow
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - s=0, co=0, ovf=0.
  - step counter and carry register cleared.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at a rising edge:
    - capture a into A_reg and (b XOR {WIDTH{sub}}) into B_reg.
    - carry_reg = ci XOR sub.
    - step=0, go to RUN.
  - RUN: in_ready=0. Each cycle:
    - add the low BITS_PER_CYC bits of A_reg and B_reg with carry_reg through a ripple chain of full-adder cells.
    - shift the slice result into the partial-sum register from the MSB end.
    - shift A_reg and B_reg right by BITS_PER_CYC.
    - update carry_reg.
    - on step==STEPS-1: load s, co, and ovf = (carry into MSB) XOR (carry out of MSB); go to DONE.
  - DONE: out_valid=1. s, co and ovf stay stable while out_valid&&!out_ready. When out_ready=1 at an edge: out_valid=0, go to IDLE.
- Arithmetic:
  - sub=0: {co,s} = a + b + ci.
  - sub=1: s = a - b - ci, computed as a + ~b + ~ci.
  - All results are modulo 2^WIDTH.
- Latency and throughput:
  - Operands accepted at edge k give out_valid=1 after edge k+STEPS.
  - Minimum spacing between accepts is STEPS+2 cycles.
- Result hold: s, co and ovf change only on the RUN->DONE transition. They keep the last result through IDLE and the following RUN.
- Boundary conditions:
  - in_valid in RUN or DONE is ignored, and no operands are captured.
  - a, b, ci and sub need to be stable only at the accept edge.
  - out_ready and in_valid both high in DONE: go to IDLE only; the new operands are accepted no earlier than the next edge.
  - out_ready in IDLE or RUN has no effect.
  - Counter wrap: step returns to 0 only on a new accept and never wraps inside RUN.

Test Plan:
1. WIDTH=8, BITS_PER_CYC=1, a=8'h00, b=8'h00, ci=0, sub=0 -> s=8'h00, co=0, ovf=0; out_valid rises exactly 8 cycles after the accept edge.
2. add a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1, ovf=0. add a=8'h7F, b=8'h01, ci=0 -> s=8'h80, co=0, ovf=1. add a=8'h0F, b=8'h00, ci=1 -> s=8'h10, co=0.
3. sub a=8'h05, b=8'h07, ci=0 -> s=8'hFE, co=0, ovf=0. sub a=8'h80, b=8'h01, ci=0 -> s=8'h7F, co=1, ovf=1. sub a=8'h10, b=8'h00, ci=1 -> s=8'h0F, co=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> out_valid, s, co and ovf stay constant, in_ready=0, and no new operation starts. On release, return to IDLE with in_ready=1 one cycle later.
5. Assert rst asynchronously in RUN at step 3 -> out_valid=0, s=0, co=0, busy=0 before the next edge. After release, a fresh add a=8'h12, b=8'h34 -> s=8'h46, co=0.
6. Sweep ci, a, b over the 8 single-bit combinations (upper bits 0) against a reference model. Then repeat with BITS_PER_CYC=4 (latency 2) and BITS_PER_CYC=8 (latency 1): a=8'hA5, b=8'h5B, ci=0 -> s=8'h00, co=1, ovf=0.

Source files
------------

// File: rtl/fa_serial_adder.sv
// fa_serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is consumed
//   BITS_PER_CYC bits per clock through a ripple chain of full-adder cells.
//   A registered carry links consecutive slices.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operand request
//   in_ready   block can accept operands (IDLE only)
//   a, b       operands
//   ci         carry-in (add) / borrow-in (sub)
//   sub        0 = add, 1 = subtract
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   s          sum / difference
//   co         carry-out; in sub mode 1 = no borrow
//   ovf        two's-complement signed overflow
//   busy       high in RUN and DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one slice of BITS_PER_CYC bits added per cycle
// DONE  | result presented, waiting for out_ready
module fa_serial_adder #(
  parameter int WIDTH        = 8,
  parameter int BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int STEPS = WIDTH / BITS_PER_CYC;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  psum_q;
  logic [WIDTH-1:0]  psum_d;
  logic              carry_q;
  logic [SW-1:0]     step_q;
  logic              last_step;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [WIDTH-1:0]  s_q;
  logic              co_q;
  logic              ovf_q;

  logic [BITS_PER_CYC-1:0] slice_sum;
  logic                    c_in_msb;
  logic                    c_out;

  // Ripple chain across the current slice. c_in_msb is the carry into the
  // top cell of the slice; on the final step that cell is the operand MSB,
  // so it feeds the overflow detect.
  always_comb begin : slice_add
    logic c;
    c         = carry_q;
    slice_sum = '0;
    c_in_msb  = 1'b0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      c_in_msb     = c;
      slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    c_out = c;
  end

  // Slice results enter at the MSB end so that after STEPS shifts the
  // first slice lands at bit 0.
  assign psum_d    = (psum_q >> BITS_PER_CYC) |
                     (WIDTH'(slice_sum) << (WIDTH - BITS_PER_CYC));
  assign last_step = (step_q == SW'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      psum_q      <= '0;
      carry_q     <= 1'b0;
      step_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      s_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            // Subtraction is a + ~b + ~ci, so invert b and the carry here.
            a_q        <= a;
            b_q        <= b ^ {WIDTH{sub}};
            carry_q    <= ci ^ sub;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> BITS_PER_CYC;
          b_q     <= b_q >> BITS_PER_CYC;
          carry_q <= c_out;
          psum_q  <= psum_d;
          if (last_step) begin
            s_q         <= psum_d;
            co_q        <= c_out;
            ovf_q       <= c_in_msb ^ c_out;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fa_serial_adder.sv
// Bench for fa_serial_adder: three instances (1, 4 and 8 bits per cycle)
// driven from a vector table, a model-checked sweep, and hand-written
// backpressure / async-reset sequences on the 1-bit-per-cycle instance.
module tb_fa_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       iv    [3];
  logic       ir    [3];
  logic [7:0] a_v   [3];
  logic [7:0] b_v   [3];
  logic       ci_v  [3];
  logic       sub_v [3];
  logic       ov    [3];
  logic       ordy  [3];
  logic [7:0] s_v   [3];
  logic       co_v  [3];
  logic       ovf_v [3];
  logic       busy_v[3];

  fa_serial_adder #(.WIDTH(8), .BITS_PER_CYC(1)) u_bpc1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_v[0]), .b(b_v[0]),
    .ci(ci_v[0]), .sub(sub_v[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .s(s_v[0]), .co(co_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]));

  fa_serial_adder #(.WIDTH(8), .BITS_PER_CYC(4)) u_bpc4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_v[1]), .b(b_v[1]),
    .ci(ci_v[1]), .sub(sub_v[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .s(s_v[1]), .co(co_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]));

  fa_serial_adder #(.WIDTH(8), .BITS_PER_CYC(8)) u_bpc8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_v[2]), .b(b_v[2]),
    .ci(ci_v[2]), .sub(sub_v[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .s(s_v[2]), .co(co_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]));

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int         u;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic [7:0] es;
    logic       eco;
    logic       eovf;
    int         elat;
  } vec_t;

  vec_t vecs[$];
  int   lat_of[3] = '{8, 2, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns {ovf, co, s}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic sub);
    logic [8:0] r;
    logic [7:0] bb;
    logic       cc;
    logic       v;
    bb = sub ? ~b : b;
    cc = ci ^ sub;
    r  = {1'b0, a} + {1'b0, bb} + {8'b0, cc};
    v  = (a[7] == bb[7]) && (r[7] != a[7]);
    return {v, r[8], r[7:0]};
  endfunction

  // Counts edges after the accept edge until out_valid is seen; 999 on timeout.
  task automatic wait_valid(input int u, output int lat);
    lat = 999;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ov[u]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input int u, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub,
                        output logic [7:0] s, output logic co, output logic ovf,
                        output int lat);
    @(posedge clk);
    #1;
    iv[u] = 1'b1; a_v[u] = a; b_v[u] = b; ci_v[u] = ci; sub_v[u] = sub;
    @(posedge clk);
    #1;
    // Operands only need to be stable at the accept edge.
    iv[u] = 1'b0; a_v[u] = 8'($urandom); b_v[u] = 8'($urandom);
    ci_v[u] = 1'($urandom); sub_v[u] = 1'($urandom);
    wait_valid(u, lat);
    s = s_v[u]; co = co_v[u]; ovf = ovf_v[u];
    ordy[u] = 1'b1;
    @(posedge clk);
    #1;
    ordy[u] = 1'b0;
    chk($sformatf("u%0d out_valid drop", u), 32'(ov[u]), 32'd0);
    chk($sformatf("u%0d in_ready back", u), 32'(ir[u]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] rs;
    logic       rco, rovf;
    int         lat;
    logic [9:0] m;

    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; a_v[i] = 0; b_v[i] = 0; ci_v[i] = 0; sub_v[i] = 0; ordy[i] = 0;
    end

    vecs.push_back('{0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8});
    vecs.push_back('{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8});
    vecs.push_back('{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8});
    vecs.push_back('{0, 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 8});
    vecs.push_back('{0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8});
    vecs.push_back('{0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8});
    vecs.push_back('{0, 8'h10, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 8});
    vecs.push_back('{0, 8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 8});
    vecs.push_back('{0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8});
    vecs.push_back('{1, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2});
    vecs.push_back('{1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 2});
    vecs.push_back('{1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 2});
    vecs.push_back('{1, 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 2});
    vecs.push_back('{2, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1});
    vecs.push_back('{2, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1});
    vecs.push_back('{2, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1});

    // Asynchronous reset: outputs must clear before any clock edge.
    #1 rst = 1'b1;
    #2;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d reset in_ready", u), 32'(ir[u]), 32'd1);
      chk($sformatf("u%0d reset out_valid", u), 32'(ov[u]), 32'd0);
      chk($sformatf("u%0d reset busy", u), 32'(busy_v[u]), 32'd0);
      chk($sformatf("u%0d reset s/co/ovf", u), {22'd0, s_v[u], co_v[u], ovf_v[u]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // out_ready in IDLE has no effect.
    ordy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle out_ready out_valid", 32'(ov[0]), 32'd0);
    chk("idle out_ready in_ready", 32'(ir[0]), 32'd1);
    ordy[0] = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].u, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, rs, rco, rovf, lat);
      chk($sformatf("vec%0d s", i), 32'(rs), 32'(vecs[i].es));
      chk($sformatf("vec%0d co", i), 32'(rco), 32'(vecs[i].eco));
      chk($sformatf("vec%0d ovf", i), 32'(rovf), 32'(vecs[i].eovf));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].elat));
    end

    // Single-bit sweep plus a few random operands on every instance.
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 16; k++) begin
        logic [7:0] ta, tb;
        logic       tci, tsub;
        ta = {7'd0, k[0]}; tb = {7'd0, k[1]}; tci = k[2]; tsub = k[3];
        m = model(ta, tb, tci, tsub);
        run_op(u, ta, tb, tci, tsub, rs, rco, rovf, lat);
        chk($sformatf("sweep u%0d k%0d", u, k), {19'd0, rs, rco, rovf, 3'(lat)},
            {19'd0, m[7:0], m[8], m[9], 3'(lat_of[u])});
      end
      for (int k = 0; k < 8; k++) begin
        logic [7:0] ta, tb;
        logic       tci, tsub;
        ta = 8'($urandom); tb = 8'($urandom); tci = 1'($urandom); tsub = 1'($urandom);
        m = model(ta, tb, tci, tsub);
        run_op(u, ta, tb, tci, tsub, rs, rco, rovf, lat);
        chk($sformatf("rand u%0d %0h %0h ci%0d sub%0d", u, ta, tb, tci, tsub),
            {22'd0, rs, rco, rovf}, {22'd0, m[7:0], m[8], m[9]});
      end
    end

    // Backpressure in DONE with in_valid held high throughout.
    @(posedge clk);
    #1;
    iv[0] = 1'b1; a_v[0] = 8'h7F; b_v[0] = 8'h01; ci_v[0] = 1'b0; sub_v[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0; a_v[0] = 8'h20; b_v[0] = 8'h03;
    wait_valid(0, lat);
    chk("bp latency", 32'(lat), 32'd8);
    iv[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp hold c%0d", n),
          {20'd0, ov[0], ir[0], busy_v[0], s_v[0], co_v[0], ovf_v[0]},
          {20'd0, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1});
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("bp release to idle",
        {21'd0, ov[0], ir[0], busy_v[0], s_v[0]}, {21'd0, 1'b0, 1'b1, 1'b0, 8'h80});
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk("bp next accept busy", {22'd0, busy_v[0], ir[0], s_v[0]}, {22'd0, 1'b1, 1'b0, 8'h80});
    wait_valid(0, lat);
    chk("bp second latency", 32'(lat), 32'd8);
    chk("bp second result", {22'd0, s_v[0], co_v[0], ovf_v[0]}, {22'd0, 8'h23, 1'b0, 1'b0});
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;

    // Async reset in RUN at step 3.
    @(posedge clk);
    #1;
    iv[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'h01; ci_v[0] = 1'b0; sub_v[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset busy", 32'(busy_v[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid-run reset",
        {20'd0, ov[0], ir[0], busy_v[0], s_v[0], co_v[0], ovf_v[0]},
        {20'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    #2 rst = 1'b0;
    run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, rs, rco, rovf, lat);
    chk("post-reset add", {21'd0, rs, rco, rovf, 1'b0}, {21'd0, 8'h46, 1'b0, 1'b0, 1'b0});
    chk("post-reset latency", 32'(lat), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
